// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet competition controller and datapath.
//   ACT_DW        activation width (IEEE-754 single precision)
//   ACT_SIGN_BIT  bit position of the activation sign
//   state_t       iteration sequencer states
//   act_is_zero   magnitude-only zero test; treats +0 and -0 as zero
package maxnet_pkg;

  localparam int ACT_DW       = 32;
  localparam int ACT_SIGN_BIT = ACT_DW - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_WAIT_VAL,
    S_CHECK,
    S_DONE
  } state_t;

  // x holds an activation of width dw (dw <= ACT_DW), zero-extended.
  // Only the bits below the sign bit of that width take part in the test.
  function automatic logic act_is_zero(input logic [ACT_DW-1:0] x, input int dw);
    logic z;
    z = 1'b1;
    for (int b = 0; b < ACT_DW - 1; b++) begin
      if ((b < dw - 1) && x[b]) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/maxnet_winner_detect.sv
// Combinational survivor analysis of the Maxnet activation vector.
//   x_flat  in   N*DW   activations, neuron i at [i*DW +: DW]
//   pop     out  CNT_W  number of non-zero neurons
//   idx     out  IDX_W  index of the lowest non-zero neuron (0 if none)
// With exactly one survivor idx is its index; with several, the lowest wins,
// which keeps the encoder well defined for malformed inputs.
module maxnet_winner_detect
  import maxnet_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = ACT_DW,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N*DW-1:0]  x_flat,
  output logic [CNT_W-1:0] pop,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] nz;

  always_comb begin
    nz  = '0;
    pop = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      nz[i] = ~act_is_zero(ACT_DW'(x_flat[i*DW +: DW]), DW);
    end
    for (int i = 0; i < N; i++) begin
      pop = pop + CNT_W'(nz[i]);
    end
    // Descending scan so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (nz[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// Iteration sequencer for the Maxnet lateral-inhibition datapath.
// Loads the initial activations, then steps the datapath until one neuron
// survives, all neurons reach zero, or MAX_ITER steps have completed.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          new competition request, honoured in IDLE or DONE
//   x_flat         datapath activations, neuron i at [i*DW +: DW]
//   step_ack       datapath completed one update (x_flat valid next cycle)
//   load_en        one-cycle pulse to load the initial activations
//   step_req       level request for one inhibition update
//   busy           high in every state except IDLE and DONE
//   done           one-cycle pulse on entry to DONE
//   winner_valid   result: single survivor
//   no_winner      result: all neurons zero
//   timeout        result: cap reached with several survivors
//   winner_idx     surviving neuron index (0 unless winner_valid)
//   iter_count     completed update steps of the current/last run
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int DW       = ACT_DW,
  parameter int MAX_ITER = 64,
  parameter int IDX_W    = $clog2(N),
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N*DW-1:0]   x_flat,
  input  logic              step_ack,
  output logic              load_en,
  output logic              step_req,
  output logic              busy,
  output logic              done,
  output logic              winner_valid,
  output logic              no_winner,
  output logic              timeout,
  output logic [IDX_W-1:0]  winner_idx,
  output logic [ITER_W-1:0] iter_count
);

  localparam int                CNT_W    = $clog2(N + 1);
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  pop;
  logic [IDX_W-1:0]  det_idx;
  logic              start_ok;
  logic              step_fire;
  logic              pop_one;
  logic              pop_zero;
  logic              at_cap;

  maxnet_winner_detect #(
    .N     (N),
    .DW    (DW),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_detect (
    .x_flat (x_flat),
    .pop    (pop),
    .idx    (det_idx)
  );

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign step_fire = (state == S_STEP) && step_ack;
  assign pop_one   = (pop == CNT_W'(1));
  assign pop_zero  = (pop == '0);
  assign at_cap    = (iter_count == ITER_CAP);

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    step_req  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_en   = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // Cap is only consulted once pop >= 2, so iter_count never passes it.
        if (pop_one || pop_zero || at_cap) state_nxt = S_DONE;
        else                               state_nxt = S_STEP;
      end
      S_STEP: begin
        step_req = 1'b1;
        if (step_ack) state_nxt = S_WAIT_VAL;
      end
      S_WAIT_VAL: begin
        state_nxt = S_CHECK;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      winner_valid <= 1'b0;
      no_winner    <= 1'b0;
      timeout      <= 1'b0;
      winner_idx   <= '0;
      iter_count   <= '0;
    end else begin
      done <= (state == S_CHECK) && (state_nxt == S_DONE);
      if (start_ok) begin
        winner_valid <= 1'b0;
        no_winner    <= 1'b0;
        timeout      <= 1'b0;
        winner_idx   <= '0;
        iter_count   <= '0;
      end else if (step_fire) begin
        iter_count <= iter_count + ITER_W'(1);
      end else if (state == S_CHECK) begin
        if (pop_one) begin
          winner_valid <= 1'b1;
          winner_idx   <= det_idx;
        end else if (pop_zero) begin
          no_winner <= 1'b1;
        end else if (at_cap) begin
          timeout    <= 1'b1;
          winner_idx <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller. Instance a uses the default cap,
// instance b uses MAX_ITER=4 for the iteration-cap scenario.
module tb_maxnet_controller;

  localparam logic [31:0] F1  = 32'h3F800000;  // 1.0
  localparam logic [31:0] F2  = 32'h40000000;  // 2.0
  localparam logic [31:0] F3  = 32'h40400000;  // 3.0
  localparam logic [31:0] F4  = 32'h40800000;  // 4.0
  localparam logic [31:0] FH  = 32'h3F000000;  // 0.5
  localparam logic [31:0] FQ  = 32'h3E800000;  // 0.25
  localparam logic [31:0] NZ0 = 32'h80000000;  // -0.0
  localparam logic [31:0] M2  = 32'hC0000000;  // -2.0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_a, ack_a, start_b, ack_b;
  logic [127:0] x_a, x_b;
  logic         load_a, req_a, busy_a, done_a, wv_a, nw_a, to_a;
  logic         load_b, req_b, busy_b, done_b, wv_b, nw_b, to_b;
  logic [1:0]   idx_a, idx_b;
  logic [6:0]   it_a;
  logic [2:0]   it_b;

  int n_cmp = 0;
  int n_err = 0;

  maxnet_controller #(.N(4), .DW(32), .MAX_ITER(64)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x_flat(x_a), .step_ack(ack_a),
    .load_en(load_a), .step_req(req_a), .busy(busy_a), .done(done_a),
    .winner_valid(wv_a), .no_winner(nw_a), .timeout(to_a),
    .winner_idx(idx_a), .iter_count(it_a)
  );

  maxnet_controller #(.N(4), .DW(32), .MAX_ITER(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x_flat(x_b), .step_ack(ack_b),
    .load_en(load_b), .step_req(req_b), .busy(busy_b), .done(done_b),
    .winner_valid(wv_b), .no_winner(nw_b), .timeout(to_b),
    .winner_idx(idx_b), .iter_count(it_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the first STEP cycle. The datapath acknowledges lat cycles
  // after step_req rises, then presents nx during WAIT_VAL.
  task automatic run_step(input bit sel, input int lat, input int k, input logic [127:0] nx);
    for (int c = 0; c <= lat; c++) begin
      chk($sformatf("step%0d_req_c%0d", k, c), 32'(sel ? req_b : req_a), 32'd1);
      chk($sformatf("step%0d_iter_c%0d", k, c), 32'(sel ? it_b : 3'(it_a)), 32'(k - 1));
      if (c == lat) begin
        if (sel) ack_b = 1'b1;
        else     ack_a = 1'b1;
      end
      tick();
    end
    ack_a = 1'b0;
    ack_b = 1'b0;
    chk($sformatf("step%0d_req_drop", k), 32'(sel ? req_b : req_a), 32'd0);
    chk($sformatf("step%0d_iter", k), 32'(sel ? 7'(it_b) : it_a), 32'(k));
    if (sel) x_b = nx;
    else     x_a = nx;
    tick();
    chk($sformatf("step%0d_check_busy", k), 32'(sel ? busy_b : busy_a), 32'd1);
    tick();
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    x_a = '0; x_b = '0;
    tick(); tick();
    chk("rst_outputs_a", {23'd0, load_a, req_a, busy_a, done_a, wv_a, nw_a, to_a, idx_a},
        32'd0);
    chk("rst_iter_a", 32'(it_a), 32'd0);
    chk("rst_outputs_b", {20'd0, load_b, req_b, busy_b, done_b, wv_b, nw_b, to_b, idx_b, it_b},
        32'd0);
    rst_n = 1'b1;
    tick();

    // Single survivor already present: no step taken, done at start+3.
    x_a = {32'd0, 32'd0, 32'd0, F3};
    start_pulse_a();
    chk("t1_load", 32'(load_a), 32'd1);
    chk("t1_busy_load", 32'(busy_a), 32'd1);
    tick();
    chk("t1_load_drop", 32'(load_a), 32'd0);
    chk("t1_req_check", 32'(req_a), 32'd0);
    chk("t1_done_early", 32'(done_a), 32'd0);
    tick();
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_flags", {29'd0, wv_a, nw_a, to_a}, 32'b100);
    chk("t1_idx", 32'(idx_a), 32'd0);
    chk("t1_iter", 32'(it_a), 32'd0);
    chk("t1_busy_done", 32'(busy_a), 32'd0);
    chk("t1_req_done", 32'(req_a), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done_a), 32'd0);
    chk("t1_hold", 32'(wv_a), 32'd1);

    // Convergence to neuron 2 after 5 steps, ack latency 2.
    x_a = {F1, F4, F2, F3};
    start_pulse_a();
    chk("t2_cleared", {29'd0, wv_a, nw_a, to_a}, 32'd0);
    tick();
    tick();
    run_step(1'b0, 2, 1, {F1, F3, F1, F2});
    run_step(1'b0, 2, 2, {FH, F2, FH, F1});
    run_step(1'b0, 2, 3, {32'd0, F2, FQ, FH});
    run_step(1'b0, 2, 4, {32'd0, F1, 32'd0, FQ});
    run_step(1'b0, 2, 5, {32'd0, FH, 32'd0, 32'd0});
    chk("t2_done", 32'(done_a), 32'd1);
    chk("t2_flags", {29'd0, wv_a, nw_a, to_a}, 32'b100);
    chk("t2_idx", 32'(idx_a), 32'd2);
    chk("t2_iter", 32'(it_a), 32'd5);

    // Tie annihilation, ack in the same cycle step_req rises; -0.0 is zero.
    x_a = {F1, F1, F1, F1};
    start_pulse_a();
    tick();
    tick();
    run_step(1'b0, 0, 1, {FH, FH, FH, FH});
    run_step(1'b0, 0, 2, {FQ, FQ, FQ, FQ});
    run_step(1'b0, 0, 3, {32'd0, 32'd0, NZ0, 32'd0});
    chk("t3_done", 32'(done_a), 32'd1);
    chk("t3_flags", {29'd0, wv_a, nw_a, to_a}, 32'b010);
    chk("t3_idx", 32'(idx_a), 32'd0);
    chk("t3_iter", 32'(it_a), 32'd3);

    // Non-converging datapath against the 4-step cap.
    x_b = {F1, F1, F1, F1};
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t4_load", 32'(load_b), 32'd1);
    tick();
    tick();
    for (int k = 1; k <= 4; k++) run_step(1'b1, 1, k, {F1, F1, F1, F1});
    chk("t4_done", 32'(done_b), 32'd1);
    chk("t4_flags", {29'd0, wv_b, nw_b, to_b}, 32'b001);
    chk("t4_iter", 32'(it_b), 32'd4);
    chk("t4_idx", 32'(idx_b), 32'd0);
    chk("t4_busy", 32'(busy_b), 32'd0);
    tick();
    chk("t4_req_after", 32'(req_b), 32'd0);

    // start ignored in STEP, then asynchronous reset while step_req is high.
    x_a = {F1, F2, F3, F4};
    start_pulse_a();
    tick();
    tick();
    chk("t5_req", 32'(req_a), 32'd1);
    start_pulse_a();
    chk("t5_start_ignored_req", 32'(req_a), 32'd1);
    chk("t5_start_ignored_load", 32'(load_a), 32'd0);
    chk("t5_start_ignored_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_req", 32'(req_a), 32'd0);
    chk("t5_async_outputs", {23'd0, load_a, req_a, busy_a, done_a, wv_a, nw_a, to_a, idx_a},
        32'd0);
    chk("t5_async_b", {29'd0, to_b, busy_b, it_b == 3'd0}, 32'd1);
    ack_a = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_late_ack_busy", 32'(busy_a), 32'd0);
    chk("t5_late_ack_req", 32'(req_a), 32'd0);
    chk("t5_late_ack_iter", 32'(it_a), 32'd0);
    ack_a = 1'b0;

    // start held on the done-pulse edge restarts immediately.
    x_a = {M2, 32'd0, 32'd0, 32'd0};
    start_pulse_a();
    tick();
    tick();
    chk("t6_done", 32'(done_a), 32'd1);
    chk("t6_idx", 32'(idx_a), 32'd3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t6_restart_load", 32'(load_a), 32'd1);
    chk("t6_restart_busy", 32'(busy_a), 32'd1);
    chk("t6_restart_cleared", {27'd0, wv_a, nw_a, to_a, idx_a}, 32'd0);
    chk("t6_restart_done", 32'(done_a), 32'd0);
    tick();
    tick();
    chk("t6_second_done", {28'd0, done_a, wv_a, idx_a}, 32'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
